// File: rtl/wcs_pkg.sv
// Shared types and helpers for the weight-chain sequencer.
package wcs_pkg;

  typedef enum logic [1:0] {
    FLUSH  = 2'd0,
    IDLE   = 2'd1,
    STREAM = 2'd2
  } wcs_state_e;

  localparam int RES_W_DEF   = 16;
  // Chain result bus carries the valid flag just above the result bits.
  localparam int RES_VLD_BIT = RES_W_DEF;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/weight_chain_sequencer_if.sv
// Stream, chain and result-FIFO signals of the weight-chain sequencer.
interface weight_chain_sequencer_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]   in_value;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   chain_index;
  logic [DATA_WIDTH-1:0]   chain_value;
  logic                    chain_enable;
  logic [RESULT_WIDTH:0]   chain_result;
  logic [RESULT_WIDTH:0]   tail_result;
  logic [RESULT_WIDTH-1:0] res_data;
  logic                    res_valid;
  logic                    res_ready;

  modport master (
    input  in_value, in_valid, tail_result, res_ready,
    output in_ready, chain_index, chain_value, chain_enable, chain_result,
           res_data, res_valid
  );

  modport slave (
    output in_value, in_valid, tail_result, res_ready,
    input  in_ready, chain_index, chain_value, chain_enable, chain_result,
           res_data, res_valid
  );
endinterface

// File: rtl/wcs_result_fifo.sv
// Synchronous show-ahead FIFO; head reads 0 while empty.
module wcs_result_fifo
  import wcs_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW   = clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             pop_ok;

  assign pop_ok = pop && (count != '0);
  assign valid  = (count != '0);
  assign head   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/weight_chain_sequencer.sv
// Drives a weight_comp chain from a vector stream and collects flagged tail results.
module weight_chain_sequencer
  import wcs_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int RESULT_WIDTH   = RES_W_DEF,
  parameter int WEIGHT_AMOUNT  = 4,
  parameter int CELL_COUNT     = 4,
  parameter int RES_FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  weight_chain_sequencer_if.master bus,
  output logic                     busy,
  output logic                     err_unexp
);
  localparam int IDX_W = clog2(WEIGHT_AMOUNT);
  localparam int CNT_W = clog2(RES_FIFO_DEPTH) + 1;
  localparam int FL_W  = clog2(CELL_COUNT + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WEIGHT_AMOUNT - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(CELL_COUNT);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RES_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CC_C     = CNT_W'(CELL_COUNT);

  wcs_state_e       state, state_nx;
  logic [FL_W-1:0]  flush_cnt, flush_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [CNT_W-1:0] reserved, fifo_count;
  logic             room_ok, start, hs;
  logic             tail_vld, push, unexp;

  // Sum of queued and promised results never exceeds DEPTH, so this cannot wrap.
  assign room_ok = (DEPTH_C - fifo_count - reserved) >= CC_C;
  assign hs      = bus.in_valid && bus.in_ready;

  always_comb begin
    state_nx     = state;
    flush_nx     = flush_cnt;
    idx_nx       = idx;
    bus.in_ready = 1'b0;
    start        = 1'b0;
    unique case (state)
      FLUSH: begin
        if (flush_cnt == FL_LAST) begin
          flush_nx = '0;
          state_nx = IDLE;
        end else begin
          flush_nx = flush_cnt + FL_W'(1);
        end
      end
      IDLE: begin
        bus.in_ready = room_ok;
        if (bus.in_valid && room_ok) begin
          start    = 1'b1;
          idx_nx   = IDX_W'(1);
          state_nx = STREAM;
        end
      end
      STREAM: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          if (idx == IDX_LAST) begin
            idx_nx   = '0;
            state_nx = IDLE;
          end else begin
            idx_nx = idx + IDX_W'(1);
          end
        end
      end
      default: state_nx = FLUSH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FLUSH;
      flush_cnt <= '0;
      idx       <= '0;
    end else begin
      state     <= state_nx;
      flush_cnt <= flush_nx;
      idx       <= idx_nx;
    end
  end

  // Chain inputs are registered; a cycle without a handshake drives a clean bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.chain_enable <= 1'b0;
      bus.chain_index  <= '0;
      bus.chain_value  <= '0;
    end else begin
      bus.chain_enable <= hs;
      bus.chain_index  <= hs ? DATA_WIDTH'(idx) : '0;
      bus.chain_value  <= hs ? bus.in_value : '0;
    end
  end

  assign bus.chain_result = '0;

  // Uninitialised cells may flag garbage while flushing, so the tail is ignored then.
  assign tail_vld = (state != FLUSH) && bus.tail_result[RESULT_WIDTH];
  assign push     = tail_vld && (reserved != '0);
  assign unexp    = tail_vld && (reserved == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reserved  <= '0;
      err_unexp <= 1'b0;
    end else begin
      reserved <= reserved + (start ? CC_C : '0) - CNT_W'(push);
      if (unexp) err_unexp <= 1'b1;
    end
  end

  assign busy = (state != IDLE) || (reserved != '0);

  wcs_result_fifo #(
    .WIDTH (RESULT_WIDTH),
    .DEPTH (RES_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.tail_result[RESULT_WIDTH-1:0]),
    .pop       (bus.res_valid && bus.res_ready),
    .head      (bus.res_data),
    .valid     (bus.res_valid),
    .count     (fifo_count)
  );
endmodule

// File: tb/tb_weight_chain_sequencer.sv
// Sequencer driving a behavioural 2-cell weight_comp chain, results checked via scoreboard.
module tb_weight_chain_sequencer;
  localparam int DW = 8;
  localparam int RW = 16;
  localparam int WA = 4;
  localparam int CC = 2;
  localparam int DEPTH = 4;

  logic clk, rst, busy, err_unexp;
  logic force_on;
  logic [RW:0] force_val;

  weight_chain_sequencer_if #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW)) bus ();

  weight_chain_sequencer #(
    .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .WEIGHT_AMOUNT(WA),
    .CELL_COUNT(CC), .RES_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .err_unexp (err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int W [WA] = '{1, 2, 3, 4};

  // Behavioural weight_comp chain: accumulate w[idx]*value, flag result after last idx,
  // forward upstream results first and emit own result when the bus is free.
  logic          c_en   [CC] = '{default: 1'b0};
  logic [DW-1:0] c_idx  [CC] = '{default: '0};
  logic [DW-1:0] c_val  [CC] = '{default: '0};
  logic [RW:0]   c_res  [CC] = '{default: '0};
  logic [RW-1:0] c_acc  [CC] = '{default: '0};
  logic [RW-1:0] c_hold [CC] = '{default: '0};
  logic          c_hv   [CC] = '{default: 1'b0};
  logic          ci_en  [CC];
  logic [DW-1:0] ci_idx [CC], ci_val [CC];
  logic [RW:0]   ci_res [CC];

  always_comb begin
    ci_en[0]  = bus.chain_enable;
    ci_idx[0] = bus.chain_index;
    ci_val[0] = bus.chain_value;
    ci_res[0] = bus.chain_result;
    for (int c = 1; c < CC; c++) begin
      ci_en[c]  = c_en[c-1];
      ci_idx[c] = c_idx[c-1];
      ci_val[c] = c_val[c-1];
      ci_res[c] = c_res[c-1];
    end
  end

  always @(posedge clk) begin : cells
    logic [RW-1:0] a;
    for (int c = 0; c < CC; c++) begin
      if (ci_res[c][RW]) c_res[c] <= ci_res[c];
      else if (c_hv[c]) begin
        c_res[c] <= {1'b1, c_hold[c]};
        c_hv[c]  <= 1'b0;
      end else c_res[c] <= '0;
      c_en[c]  <= ci_en[c];
      c_idx[c] <= ci_idx[c];
      c_val[c] <= ci_val[c];
      if (ci_en[c]) begin
        a = (ci_idx[c] == 0 ? '0 : c_acc[c]) + RW'(W[ci_idx[c][1:0]] * int'(ci_val[c]));
        c_acc[c] <= a;
        if (ci_idx[c] == DW'(WA - 1)) begin
          c_hold[c] <= a;
          c_hv[c]   <= 1'b1;
        end
      end
    end
  end

  assign bus.tail_result = force_on ? force_val : c_res[CC-1];

  int n_chk = 0;
  int n_pass = 0;
  int exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) chk("res_extra_q", exp_q.size(), 1);
      else chk("res_data", 32'(bus.res_data), exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_check(input string tag);
    for (int i = 0; i < CC + 1; i++) begin
      chk({tag, "_fl_rdy"}, bus.in_ready, 0);
      chk({tag, "_fl_en"}, bus.chain_enable, 0);
      tick();
    end
    chk({tag, "_idle_rdy"}, bus.in_ready, 1);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  task automatic send_vec(input int v[WA], input int gap_at, input int gap_len,
                          input int n_send, input bit chk_chain);
    int dot, t;
    dot = 0;
    for (int i = 0; i < WA; i++) dot += W[i] * v[i];
    if (n_send == WA) for (int c = 0; c < CC; c++) exp_q.push_back(dot);
    for (int i = 0; i < n_send; i++) begin
      bus.in_value = DW'(v[i]);
      bus.in_valid = 1'b1;
      t = 0;
      while (1) begin
        @(negedge clk);
        if (bus.in_ready) break;
        t++;
        if (t > 200) begin
          chk("in_ready_timeout", bus.in_ready, 1);
          break;
        end
      end
      tick();
      bus.in_valid = 1'b0;
      if (chk_chain) begin
        chk("ch_en", bus.chain_enable, 1);
        chk("ch_idx", bus.chain_index, i);
        chk("ch_val", bus.chain_value, v[i]);
      end
      if (i == gap_at)
        for (int g = 0; g < gap_len; g++) begin
          tick();
          chk("gap_en", bus.chain_enable, 0);
        end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 60) begin
      tick();
      t++;
    end
    chk("idle_wait", busy, 0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      tick();
      t++;
    end
    tick();
    chk("drain_q", exp_q.size(), 0);
  endtask

  task automatic pop_one();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_value = '0;
    bus.res_ready = 1'b0;
    force_on = 1'b0;
    force_val = '0;

    // 1: reset state and flush
    repeat (3) tick();
    chk("rst_en", bus.chain_enable, 0);
    chk("rst_rdy", bus.in_ready, 0);
    chk("rst_rv", bus.res_valid, 0);
    chk("rst_err", err_unexp, 0);
    chk("rst_cres", 32'(bus.chain_result), 0);
    rst = 1'b0;
    flush_check("t1");

    // 2: one vector without gaps
    send_vec('{1, 2, 3, 4}, -1, 0, WA, 1'b1);
    wait_idle();
    chk("t2_rv", bus.res_valid, 1);
    bus.res_ready = 1'b1;
    drain();
    chk("t2_rv0", bus.res_valid, 0);
    chk("t2_busy", busy, 0);

    // 3: back-to-back vectors fill the reservation
    bus.res_ready = 1'b0;
    send_vec('{1, 1, 1, 1}, -1, 0, WA, 1'b0);
    send_vec('{2, 0, 1, 3}, -1, 0, WA, 1'b0);
    wait_idle();
    chk("t3_full_rdy", bus.in_ready, 0);
    pop_one();
    chk("t3_pop1_rdy", bus.in_ready, 0);
    pop_one();
    chk("t3_pop2_rdy", bus.in_ready, 1);
    send_vec('{4, 3, 2, 1}, -1, 0, WA, 1'b0);
    bus.res_ready = 1'b1;
    drain();

    // 4: mid-vector gap
    send_vec('{1, 2, 3, 4}, 1, 3, WA, 1'b1);
    drain();

    // 5: unexpected flagged result while idle
    wait_idle();
    force_val = 17'h1_0005;
    force_on = 1'b1;
    tick();
    force_on = 1'b0;
    chk("t5_err", err_unexp, 1);
    tick();
    tick();
    chk("t5_rv", bus.res_valid, 0);

    // 6: reset mid-vector, then a fresh vector
    send_vec('{5, 6, 7, 8}, -1, 0, 3, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_en", bus.chain_enable, 0);
    chk("t6_idx", bus.chain_index, 0);
    chk("t6_val", bus.chain_value, 0);
    chk("t6_rdy", bus.in_ready, 0);
    chk("t6_err", err_unexp, 0);
    tick();
    tick();
    rst = 1'b0;
    flush_check("t6");
    send_vec('{2, 2, 2, 2}, -1, 0, WA, 1'b1);
    drain();
    chk("t6_rv0", bus.res_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
